// File: rtl/cs_pkg.sv
// cs_pkg: shared widths, sample/sum types and small arithmetic helpers for the CS filter
package cs_pkg;
  localparam int DW   = 8;
  localparam int WIN  = 9;
  localparam int SUMW = 12;
  localparam int TW   = 13;
  localparam int YW   = 10;
  typedef logic [DW-1:0]   sample_t;
  typedef logic [SUMW-1:0] sum_t;
  function automatic sum_t nine(sample_t x);
    return (sum_t'(x) << 3) + sum_t'(x);
  endfunction
  function automatic sample_t mx(sample_t a, sample_t b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/cs_if.sv
// cs_if: sample stream in, filtered result out
interface cs_if import cs_pkg::*; ();
  sample_t       x;
  logic [YW-1:0] y;
  modport master (output x, input y);
  modport slave  (input x, output y);
endinterface

// File: rtl/cs_appr_sel.sv
// cs_appr_sel: pick the largest window sample whose ninefold value does not exceed the window sum
module cs_appr_sel import cs_pkg::*; (
  input  sample_t w [WIN],
  input  sum_t    s,
  output sample_t xappr
);
  sample_t c  [WIN];
  sample_t m1 [4];
  sample_t m2 [2];
  sample_t m3;
  // force non-qualifying samples to zero, then reduce with a balanced max tree
  always_comb begin
    for (int k = 0; k < WIN; k++) c[k] = (nine(w[k]) <= s) ? w[k] : '0;
    for (int k = 0; k < 4; k++) m1[k] = mx(c[2*k], c[2*k+1]);
    m2[0] = mx(m1[0], m1[1]);
    m2[1] = mx(m1[2], m1[3]);
    m3 = mx(m2[0], m2[1]);
    xappr = mx(m3, c[8]);
  end
endmodule

// File: rtl/cs.sv
// cs: 9-tap sliding-window smoothing filter, Y = (sum + 9*Xappr) / 8
module cs import cs_pkg::*; (
  input logic clk,
  input logic reset,
  cs_if.slave bus
);
  sample_t         w_q [WIN];
  sample_t         w_d [WIN];
  sum_t            s1 [4];
  sum_t            s2 [2];
  sum_t            s3;
  sum_t            s;
  sample_t         xappr;
  logic [TW-1:0]   t;
  // next window: newest sample enters at tap 0, everything else moves one tap older
  always_comb begin
    w_d[0] = bus.x;
    for (int i = 1; i < WIN; i++) w_d[i] = w_q[i-1];
  end
  // window register with synchronous active-low clear
  always_ff @(posedge clk) begin
    if (!reset) for (int i = 0; i < WIN; i++) w_q[i] <= '0;
    else        for (int i = 0; i < WIN; i++) w_q[i] <= w_d[i];
  end
  // balanced adder tree for the window sum
  always_comb begin
    for (int i = 0; i < 4; i++) s1[i] = sum_t'(w_q[2*i]) + sum_t'(w_q[2*i+1]);
    s2[0] = s1[0] + s1[1];
    s2[1] = s1[2] + s1[3];
    s3 = s2[0] + s2[1];
    s = s3 + sum_t'(w_q[8]);
  end
  cs_appr_sel u_sel (.w(w_q), .s(s), .xappr(xappr));
  // final add and truncating divide by eight
  always_comb begin
    t = TW'(s) + TW'(nine(xappr));
    bus.y = YW'(t >> 3);
  end
endmodule

// File: tb/tb_cs.sv
// tb_cs: directed window vectors, reset/boundary sequences and a random stream against a queue model
`timescale 1ns/100ps
module tb_cs;
  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;
  int   mw [$];

  cs_if bus ();
  cs dut (.clk(clk), .reset(reset), .bus(bus));

  always #4.6 clk = ~clk;

  typedef struct {
    string              name;
    logic [8:0][7:0]    x;
    int                 y;
  } vec_t;

  function automatic int ref_y();
    int s = 0;
    int a = 0;
    foreach (mw[i]) s += mw[i];
    foreach (mw[i]) if (9 * mw[i] <= s && mw[i] > a) a = mw[i];
    return (s + 9 * a) / 8;
  endfunction

  task automatic tick(input logic [7:0] xv, input logic rv);
    @(negedge clk);
    bus.x = xv;
    reset = rv;
    @(posedge clk);
    #1;
    if (!rv) begin
      mw.delete();
      repeat (9) mw.push_back(0);
    end else begin
      mw.push_front(int'(xv));
      void'(mw.pop_back());
    end
  endtask

  task automatic check(input string name, input logic [9:0] got, input int exp);
    n_vec++;
    if ($isunknown(got) || int'(got) != exp) begin
      n_err++;
      $display("FAIL %s: Y=%0d expected %0d", name, got, exp);
    end
  endtask

  initial begin
    vec_t tbl [5];
    logic [7:0] xr;
    tbl[0] = '{"const16", {9{8'h10}}, 36};
    tbl[1] = '{"all255",  {9{8'hFF}}, 573};
    tbl[2] = '{"all0",    {9{8'h00}}, 0};
    tbl[3] = '{"mixed",   {8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, 11};
    tbl[4] = '{"skewed",  {8'd200, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 25};
    repeat (9) mw.push_back(0);
    reset = 1'b0;
    bus.x = 8'h55;
    tick(8'h55, 1'b0);
    check("reset0", bus.y, 0);
    tick(8'h55, 1'b0);
    check("reset1", bus.y, 0);
    for (int v = 0; v < 5; v++) begin
      for (int j = 0; j < 9; j++) tick(tbl[v].x[j], 1'b1);
      check(tbl[v].name, bus.y, tbl[v].y);
      check({tbl[v].name, "_model"}, bus.y, ref_y());
    end
    repeat (9) tick(8'hFF, 1'b1);
    check("prefill255", bus.y, 573);
    tick(8'hFF, 1'b0);
    check("midreset", bus.y, 0);
    tick(8'h80, 1'b1);
    check("post_reset_first", bus.y, 16);
    for (int i = 0; i < 20; i++) begin
      tick(8'h10, 1'b1);
      if (i >= 8) check("hold16", bus.y, 36);
    end
    tick(8'h00, 1'b0);
    for (int i = 0; i < 2000; i++) begin
      case ($urandom_range(0, 3))
        0:       xr = 8'($urandom_range(0, 15));
        1:       xr = 8'($urandom_range(240, 255));
        default: xr = 8'($urandom);
      endcase
      tick(xr, 1'b1);
      if (i >= 8) check("random", bus.y, ref_y());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
